// File: rtl/sht40_pkg.sv
`default_nettype none
// =============================================================================
// sht40_pkg - FSM encoding, default conversion constants and BCD helper
// Revision: 1.0
// =============================================================================
package sht40_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ADJ  = 3'd2,
        BCD  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [15:0] c_t_scale   = 16'd17500;
    localparam logic [15:0] c_t_offset  = 16'd4500;
    localparam logic [15:0] c_rh_scale  = 16'd12500;
    localparam logic [15:0] c_rh_offset = 16'd600;
    localparam logic [15:0] c_rh_max    = 16'd10000;

    localparam logic SEL_TEMP = 1'b0;
    localparam logic SEL_RH   = 1'b1;

    // One double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [19:0] bcd_add3(input logic [19:0] d);
        logic [19:0] adj;
        adj = d;
        for (int i = 0; i < 5; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sht40_convert_if.sv
`default_nettype none
// =============================================================================
// sht40_convert_if - raw-sample inputs and converted-result outputs
// Revision: 1.0
// =============================================================================
interface sht40_convert_if;
    logic [15:0] i_temp;
    logic [15:0] i_rh;
    logic        i_r_temp;
    logic        i_r_rh;
    logic        o_valid;
    logic        o_sel;
    logic [15:0] o_value;
    logic        o_neg;
    logic [19:0] o_bcd;
    logic        o_busy;
    logic        o_drop;

    modport master (
        output i_temp, i_rh, i_r_temp, i_r_rh,
        input  o_valid, o_sel, o_value, o_neg, o_bcd, o_busy, o_drop
    );

    modport slave (
        input  i_temp, i_rh, i_r_temp, i_r_rh,
        output o_valid, o_sel, o_value, o_neg, o_bcd, o_busy, o_drop
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// =============================================================================
// bin2bcd_seq - 16-bit binary to 5-digit BCD, double-dabble, 16 cycles
// Revision: 1.0
// =============================================================================
module bin2bcd_seq
    import sht40_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start,
    input  wire logic [15:0] bin,
    output logic      [19:0] bcd,
    output logic             done
);

    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [19:0] w_adj;

    assign w_adj = bcd_add3(r_bcd);
    assign bcd   = r_bcd;
    assign done  = r_done;

    // The start edge already performs the first shift, so done rises 16 edges
    // after start and the result is valid (and held) from that cycle on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin  <= {bin[14:0], 1'b0};
                r_bcd  <= {19'd0, bin[15]};
                r_cnt  <= 4'd1;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd <= (w_adj << 1) | {19'd0, r_bin[15]};
                r_bin <= {r_bin[14:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sht40_convert.sv
`default_nettype none
// =============================================================================
// sht40_convert - SHT40 raw ticks to signed hundredths plus packed BCD
// Revision: 1.0
// =============================================================================
module sht40_convert
    import sht40_pkg::*;
#(
    parameter logic [15:0] T_SCALE   = c_t_scale,
    parameter logic [15:0] T_OFFSET  = c_t_offset,
    parameter logic [15:0] RH_SCALE  = c_rh_scale,
    parameter logic [15:0] RH_OFFSET = c_rh_offset,
    parameter logic [15:0] RH_MAX    = c_rh_max
)
(
    input  wire logic       clk,
    input  wire logic       rst,
    sht40_convert_if.slave  bus
);

    state_t r_state, w_next;

    logic [15:0] r_raw_t, r_raw_h;
    logic        r_pend_t, r_pend_h, r_cool, r_drop;
    logic        r_sel;
    logic [15:0] r_mplier;
    logic [31:0] r_addend, r_prod;
    logic [3:0]  r_cnt;
    logic [15:0] r_value;
    logic        r_neg;
    logic        r_valid, r_osel, r_oneg;
    logic [15:0] r_ovalue;
    logic [19:0] r_obcd;

    logic               w_idle_ok, w_disp_t, w_disp_h;
    logic        [15:0] w_off;
    logic signed [16:0] w_v;
    logic        [15:0] w_value, w_mag;
    logic               w_neg;
    logic        [19:0] w_bcd_out;
    logic               w_bcd_done;

    // r_cool blocks dispatch for the IDLE cycle right after a result, which
    // separates back-to-back conversions by one quiet cycle.
    assign w_idle_ok = (r_state == IDLE) && !r_cool;
    assign w_disp_t  = w_idle_ok && r_pend_t;
    assign w_disp_h  = w_idle_ok && r_pend_h && !r_pend_t;

    assign w_off = (r_sel == SEL_RH) ? RH_OFFSET : T_OFFSET;
    assign w_v   = $signed({1'b0, r_prod[31:16]}) - $signed({1'b0, w_off});

    always_comb begin
        w_value = w_v[15:0];
        w_mag   = w_v[15:0];
        w_neg   = 1'b0;
        if (r_sel == SEL_RH) begin
            if (w_v[16]) begin
                w_value = '0;
                w_mag   = '0;
            end else if (w_v[15:0] > RH_MAX) begin
                w_value = RH_MAX;
                w_mag   = RH_MAX;
            end
        end else if (w_v[16]) begin
            w_neg = 1'b1;
            w_mag = ~w_v[15:0] + 16'd1;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (r_state == ADJ),
        .bin   (w_mag),
        .bcd   (w_bcd_out),
        .done  (w_bcd_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_disp_t || w_disp_h) w_next = MUL;
            MUL:     if (r_cnt == 4'd15)       w_next = ADJ;
            ADJ:     w_next = BCD;
            BCD:     if (w_bcd_done)           w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Capture runs in every state; a strobe onto an undispatched word is a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw_t  <= '0;
            r_raw_h  <= '0;
            r_pend_t <= 1'b0;
            r_pend_h <= 1'b0;
            r_drop   <= 1'b0;
            r_cool   <= 1'b0;
        end else begin
            if (bus.i_r_temp) r_raw_t <= bus.i_temp;
            if (bus.i_r_rh)   r_raw_h <= bus.i_rh;
            if (bus.i_r_temp)  r_pend_t <= 1'b1;
            else if (w_disp_t) r_pend_t <= 1'b0;
            if (bus.i_r_rh)    r_pend_h <= 1'b1;
            else if (w_disp_h) r_pend_h <= 1'b0;
            r_drop <= (bus.i_r_temp && r_pend_t && !w_disp_t) ||
                      (bus.i_r_rh   && r_pend_h && !w_disp_h);
            r_cool <= (r_state == DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel    <= SEL_TEMP;
            r_mplier <= '0;
            r_addend <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_value  <= '0;
            r_neg    <= 1'b0;
            r_valid  <= 1'b0;
            r_osel   <= 1'b0;
            r_ovalue <= '0;
            r_oneg   <= 1'b0;
            r_obcd   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_disp_t || w_disp_h) begin
                        r_sel    <= w_disp_t ? SEL_TEMP : SEL_RH;
                        r_mplier <= w_disp_t ? r_raw_t : r_raw_h;
                        r_addend <= {16'd0, (w_disp_t ? T_SCALE : RH_SCALE)};
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end
                end
                MUL: begin
                    if (r_mplier[0]) r_prod <= r_prod + r_addend;
                    r_mplier <= {1'b0, r_mplier[15:1]};
                    r_addend <= {r_addend[30:0], 1'b0};
                    r_cnt    <= r_cnt + 4'd1;
                end
                ADJ: begin
                    r_value <= w_value;
                    r_neg   <= w_neg;
                end
                DONE: begin
                    r_valid  <= 1'b1;
                    r_osel   <= r_sel;
                    r_ovalue <= r_value;
                    r_oneg   <= r_neg;
                    r_obcd   <= w_bcd_out;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_valid = r_valid;
    assign bus.o_sel   = r_osel;
    assign bus.o_value = r_ovalue;
    assign bus.o_neg   = r_oneg;
    assign bus.o_bcd   = r_obcd;
    assign bus.o_busy  = (r_state != IDLE);
    assign bus.o_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sht40_convert.sv
`default_nettype none
// =============================================================================
// tb_sht40_convert - directed vectors with a queue-based result scoreboard
// Revision: 1.0
// =============================================================================
module tb_sht40_convert;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sht40_convert_if bus ();

    sht40_convert dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        sel;
        logic [15:0] value;
        logic        neg;
        logic [19:0] bcd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   drops  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_res(input logic sel, input logic [15:0] value, input logic neg,
                              input logic [19:0] bcd, input int due);
        exp_t e;
        e.sel = sel; e.value = value; e.neg = neg; e.bcd = bcd; e.due = due;
        sb.push_back(e);
    endtask

    // Strobe is sampled on the edge after 'at'; the result is seen at negedge of cycle at+36.
    task automatic drive(input logic t, input logic [15:0] tv, input logic h,
                         input logic [15:0] hv, output int at);
        @(posedge clk); #1;
        bus.i_r_temp = t; bus.i_temp = tv;
        bus.i_r_rh   = h; bus.i_rh   = hv;
        at = cyc;
        @(posedge clk); #1;
        bus.i_r_temp = 1'b0;
        bus.i_r_rh   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results still outstanding, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    // Monitor: pops one expectation per o_valid pulse.
    always @(negedge clk) begin
        if (!rst && bus.o_drop) drops++;
        if (!rst && bus.o_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: o_valid=1 with empty scoreboard (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("sel",     {31'd0, bus.o_sel},  {31'd0, mon_e.sel});
                chk("value",   {16'd0, bus.o_value}, {16'd0, mon_e.value});
                chk("neg",     {31'd0, bus.o_neg},  {31'd0, mon_e.neg});
                chk("bcd",     {12'd0, bus.o_bcd},  {12'd0, mon_e.bcd});
                chk("latency", cyc, mon_e.due);
            end
        end
    end

    logic        v_ch  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] v_raw [6] = '{16'h6666, 16'h0000, 16'hFFFF, 16'h0000, 16'h8000, 16'hFFFF};
    logic [15:0] v_val [6] = '{16'd2499, 16'hEE6C, 16'd12999, 16'd0, 16'd5650, 16'd10000};
    logic        v_neg [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [19:0] v_bcd [6] = '{20'h02499, 20'h04500, 20'h12999, 20'h00000, 20'h05650, 20'h10000};

    initial begin
        int at;
        bus.i_temp = '0; bus.i_rh = '0; bus.i_r_temp = 1'b0; bus.i_r_rh = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("rst_busy",  {31'd0, bus.o_busy},  32'd0);
        chk("rst_drop",  {31'd0, bus.o_drop},  32'd0);
        chk("rst_value", {16'd0, bus.o_value}, 32'd0);
        chk("rst_bcd",   {12'd0, bus.o_bcd},   32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (v_ch[i]) drive(1'b0, 16'h0000, 1'b1, v_raw[i], at);
            else         drive(1'b1, v_raw[i], 1'b0, 16'h0000, at);
            expect_res(v_ch[i], v_val[i], v_neg[i], v_bcd[i], at + 36);
            repeat (2) @(negedge clk);
            chk("busy_during", {31'd0, bus.o_busy}, 32'd1);
            drain("single");
            chk("busy_after", {31'd0, bus.o_busy}, 32'd0);
        end

        repeat (10) @(negedge clk);
        chk("hold_value", {16'd0, bus.o_value}, 32'd10000);
        chk("hold_sel",   {31'd0, bus.o_sel},   32'd1);
        chk("hold_bcd",   {12'd0, bus.o_bcd},   32'h10000);
        chk("drops_none", drops, 0);

        // Simultaneous strobes: temperature first, humidity one gap cycle later.
        drive(1'b1, 16'h6666, 1'b1, 16'h8000, at);
        expect_res(1'b0, 16'd2499, 1'b0, 20'h02499, at + 36);
        expect_res(1'b1, 16'd5650, 1'b0, 20'h05650, at + 72);
        drain("simultaneous");
        chk("drops_simul", drops, 0);

        // Two humidity words while busy: the second overwrites the first.
        drive(1'b1, 16'h6666, 1'b0, 16'h0000, at);
        expect_res(1'b0, 16'd2499, 1'b0, 20'h02499, at + 36);
        expect_res(1'b1, 16'd5650, 1'b0, 20'h05650, at + 72);
        begin
            int t2;
            repeat (3) @(posedge clk);
            drive(1'b0, 16'h0000, 1'b1, 16'h1000, t2);
            repeat (2) @(posedge clk);
            drive(1'b0, 16'h0000, 1'b1, 16'h8000, t2);
        end
        drain("overwrite");
        chk("drops_overwrite", drops, 1);

        // Reset in the middle of a conversion.
        drive(1'b1, 16'hFFFF, 1'b0, 16'h0000, at);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.o_valid}, 32'd0);
        chk("midrst_busy",  {31'd0, bus.o_busy},  32'd0);
        chk("midrst_value", {16'd0, bus.o_value}, 32'd0);
        chk("midrst_sel",   {31'd0, bus.o_sel},   32'd0);
        chk("midrst_bcd",   {12'd0, bus.o_bcd},   32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_after_rst", {31'd0, bus.o_busy}, 32'd0);
        drive(1'b1, 16'h6666, 1'b0, 16'h0000, at);
        expect_res(1'b0, 16'd2499, 1'b0, 20'h02499, at + 36);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sht40_convert.md
Name: sht40_convert

Overview:
- Sits downstream of the SHT40 measurement stage (consumes raw 16-bit temperature/humidity words and their 1-cycle ready strobes) and upstream of the 7-segment display driver.
- Converts raw sensor ticks to physical units in hundredths (centi-°C, centi-%RH) using a sequential shift-add multiplier.
- Converts the magnitude to 5-digit packed BCD with a sequential double-dabble, then presents the result with a 1-cycle valid strobe.

Parameters:
- T_SCALE, 17500, temperature span ×100 (175.00 °C)
- T_OFFSET, 4500, temperature offset ×100 (45.00 °C), subtracted
- RH_SCALE, 12500, humidity span ×100 (125.00 %)
- RH_OFFSET, 600, humidity offset ×100 (6.00 %), subtracted
- RH_MAX, 10000, humidity upper clamp (100.00 %)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_temp  in  16  raw temperature ticks, valid when i_r_temp=1
- i_rh  in  16  raw humidity ticks, valid when i_r_rh=1
- i_r_temp  in  1  1-cycle strobe, i_temp valid
- i_r_rh  in  1  1-cycle strobe, i_rh valid
- o_valid  out  1  1-cycle strobe, result outputs updated
- o_sel  out  1  0 = temperature result, 1 = humidity result
- o_value  out  16  signed result in hundredths
- o_neg  out  1  result is negative (temperature only)
- o_bcd  out  20  |o_value| as 5 packed BCD digits, MS digit first
- o_busy  out  1  conversion in progress
- o_drop  out  1  1-cycle strobe, a pending raw word was overwritten

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; FSM goes to IDLE.
  - Pending flags and raw latches are cleared.
  - An in-flight conversion is abandoned with no o_valid.
- Capture: every input strobe is latched into its per-channel raw register and sets that channel's pending flag. Capture happens in any state.
- Overwrite: a strobe on a channel whose pending flag is already set overwrites the raw word (latest wins) and pulses o_drop for 1 cycle.
- Dispatch (IDLE only):
  - If any pending flag is set, clear that channel's flag and start that channel on the next edge.
  - Temperature has priority when both are pending.
  - Simultaneous i_r_temp and i_r_rh in IDLE: temperature converts first; humidity stays pending and starts immediately after DONE.
- FSM states and transitions:
  - IDLE → MUL: a channel is dispatched.
  - MUL, 16 cycles: product = SCALE × raw, 32-bit, shift-add one raw bit per cycle LSB-first; then → ADJ.
  - ADJ, 1 cycle: v = (product >> 16) − OFFSET, signed 17-bit.
    - Humidity: clamp v to [0, RH_MAX].
    - Temperature: no clamp. Range is −4500..12999.
    - Form o_neg and |v|; → BCD.
  - BCD, 16 cycles: double-dabble of the 16-bit magnitude into 20-bit BCD (add 3 to any nibble ≥5, then shift); → DONE.
  - DONE, 1 cycle: register o_sel/o_value/o_neg/o_bcd, pulse o_valid; → IDLE.
- Latency: from the edge sampling a strobe in IDLE to o_valid high is exactly 35 cycles (1 dispatch + 16 + 1 + 16 + 1). Back-to-back conversions add 1 IDLE cycle between them.
- Outputs hold their last values between o_valid pulses.
- o_busy = (state ≠ IDLE).
- Division by 65535 is approximated by >>16 (truncation); this is the defined arithmetic.

Decomposition:
- Package sht40_pkg: FSM state encoding (IDLE, MUL, ADJ, BCD, DONE), default scale/offset/clamp constants, channel-select constants (SEL_TEMP=0, SEL_RH=1).
- Sub-module bin2bcd_seq: start/done handshake, 16-bit binary in, 20-bit BCD out, fixed 16 cycles. Reused later by the display path.

Test Plan:
- Temperature pulse, i_temp=0x6666 → after 35 cycles: o_valid=1, o_sel=0, o_value=2499, o_neg=0, o_bcd=0x02499.
- Temperature i_temp=0x0000 → o_value=−4500, o_neg=1, o_bcd=0x04500. Temperature i_temp=0xFFFF → o_value=12999, o_bcd=0x12999.
- Humidity i_rh=0x8000 → o_sel=1, o_value=5650, o_bcd=0x05650. Humidity i_rh=0xFFFF → clamps to 10000, o_bcd=0x10000. Humidity i_rh=0x0000 → clamps to 0, o_bcd=0x00000.
- Simultaneous strobes, temp=0x6666 and rh=0x8000 → temperature result at +35 cycles, humidity result at +71 cycles, no o_drop.
- While busy, two i_r_rh strobes with 0x1000 then 0x8000 → o_drop pulses once; the humidity result is 5650.
- rst asserted at cycle 20 of a conversion → outputs 0 at once, no o_valid, o_busy=0; a fresh strobe after release converts normally in 35 cycles.
